// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host blocks: transmitter state encoding,
// well-known keyboard command/response bytes, default timing constants and
// the odd-parity helper used when a command byte is framed.
// ---------------------------------------------------------------------------
package ps2_pkg;

   // Host transmitter states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      XFER      = 3'd3,
      WAIT_IDLE = 3'd4,
      DONE      = 3'd5,
      FAIL      = 3'd6
   } ps2_tx_state_e;

   // Keyboard command / response bytes
   localparam logic [7:0] CMD_SET_LED  = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;
   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   // Default timing, in system clock cycles at 100 MHz
   localparam int unsigned FILTER_CYC_DEF        = 32'd20;
   localparam int unsigned INHIBIT_CYC_DEF       = 32'd10000;
   localparam int unsigned START_TIMEOUT_CYC_DEF = 32'd1500000;
   localparam int unsigned EDGE_TIMEOUT_CYC_DEF  = 32'd200000;

   // PS/2 uses odd parity: the parity bit makes the 9-bit total odd
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw PS/2 pin into the clk domain (2-FF synchronizer) and
// removes glitches: the filtered output only follows the synchronized level
// after FILTER_CYC consecutive samples that differ from the current output.
// Shared by the host transmitter and the keyboard receiver.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous reset, active low (output resets to 1 = idle)
//   line_i  in  raw pin level
//   filt_o  out synchronized, filtered pin level
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int unsigned FILTER_CYC = 32'd20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic filt_o
);

   localparam int unsigned CW = $clog2(FILTER_CYC + 32'd1);

   logic [1:0]    sync_q;
   logic          filt_q;
   logic          filt_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Synchronizer, filtered level and run-length counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   // Count consecutive samples that disagree with the output; any agreeing
   // sample restarts the count, so only a stable new level gets through.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER_CYC - 32'd1)) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CW'(1'b1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Accepts one command byte over a
// valid/ready handshake, inhibits the bus, issues request-to-send, shifts
// the byte out LSB first on device clock falling edges, appends odd parity
// and stop, then checks the device ACK. Reports a one-cycle done or err.
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   kclk_in, kdata_in    raw PS/2 clock / data pin levels
//   kclk_oe, kdata_oe    1 = pull the open-drain line low, 0 = release
//   tx_data, tx_valid    command byte offered
//   tx_ready             idle, a byte can be accepted
//   busy                 transaction in progress (receiver ignores pins)
//   done                 one-cycle pulse: byte sent and ACK seen
//   err                  one-cycle pulse: timeout or missing ACK
//
// Timer width is sized for START_TIMEOUT_CYC; INHIBIT_CYC and
// EDGE_TIMEOUT_CYC must not exceed it.
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_CYC        = FILTER_CYC_DEF,
   parameter int unsigned INHIBIT_CYC       = INHIBIT_CYC_DEF,
   parameter int unsigned START_TIMEOUT_CYC = START_TIMEOUT_CYC_DEF,
   parameter int unsigned EDGE_TIMEOUT_CYC  = EDGE_TIMEOUT_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned TW = $clog2(START_TIMEOUT_CYC + 32'd1);

   ps2_tx_state_e state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [8:0]    frame_q, frame_d;      // {parity, data}
   logic          kclk_oe_q, kclk_oe_d;
   logic          kdata_oe_q, kdata_oe_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          clk_filt_s;
   logic          data_filt_s;
   logic          clk_prev_q;
   logic          fe_q;

   ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (kclk_in),
      .filt_o (clk_filt_s)
   );

   ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_data_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (kdata_in),
      .filt_o (data_filt_s)
   );

   // Registered falling-edge detect on the filtered device clock
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_prev_q <= 1'b1;
         fe_q       <= 1'b0;
      end else begin
         clk_prev_q <= clk_filt_s;
         fe_q       <= clk_prev_q & ~clk_filt_s;
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         cnt_q      <= 4'd0;
         frame_q    <= 9'd0;
         kclk_oe_q  <= 1'b0;
         kdata_oe_q <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         kclk_oe_q  <= kclk_oe_d;
         kdata_oe_q <= kdata_oe_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so that every pin and status bit comes from a flop.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      cnt_d      = cnt_q;
      frame_d    = frame_q;
      kclk_oe_d  = kclk_oe_q;
      kdata_oe_d = kdata_oe_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d      = 4'd0;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            if (tx_valid && ready_q) begin
               state_d   = INHIBIT;
               timer_d   = TW'(INHIBIT_CYC - 32'd1);
               frame_d   = {odd_parity(tx_data), tx_data};
               kclk_oe_d = 1'b1;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         INHIBIT: begin
            cnt_d = 4'd0;
            if (timer_q == '0) begin
               // Start bit goes low while the clock is still held
               state_d    = REQ;
               kdata_oe_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1'b1);
            end
         end

         REQ: begin
            cnt_d     = 4'd0;
            state_d   = XFER;
            kclk_oe_d = 1'b0;
            timer_d   = TW'(START_TIMEOUT_CYC - 32'd1);
         end

         XFER: begin
            if (fe_q) begin
               cnt_d   = cnt_q + 4'd1;
               timer_d = TW'(EDGE_TIMEOUT_CYC - 32'd1);
               if (cnt_q < 4'd9) begin
                  // Edges 1..9: data bits LSB first, then parity
                  kdata_oe_d = ~frame_q[cnt_q];
               end else if (cnt_q == 4'd9) begin
                  // Edge 10: stop bit, line released
                  kdata_oe_d = 1'b0;
               end else begin
                  // Edge 11: device must be pulling data low as ACK
                  kdata_oe_d = 1'b0;
                  if (data_filt_s) begin
                     state_d   = FAIL;
                     err_d     = 1'b1;
                     kclk_oe_d = 1'b0;
                  end else begin
                     state_d = WAIT_IDLE;
                  end
               end
            end else if (timer_q == '0) begin
               state_d    = FAIL;
               err_d      = 1'b1;
               kclk_oe_d  = 1'b0;
               kdata_oe_d = 1'b0;
            end else begin
               timer_d = timer_q - TW'(1'b1);
            end
         end

         WAIT_IDLE: begin
            if (clk_filt_s && data_filt_s) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (timer_q == '0) begin
               state_d    = FAIL;
               err_d      = 1'b1;
               kclk_oe_d  = 1'b0;
               kdata_oe_d = 1'b0;
            end else begin
               timer_d = timer_q - TW'(1'b1);
            end
         end

         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end

         FAIL: begin
            state_d    = IDLE;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
         end

         default: begin
            state_d    = IDLE;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   assign kclk_oe  = kclk_oe_q;
   assign kdata_oe = kdata_oe_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a cycle-based PS/2 device model on
// open-drain lines. Bytes are pushed to a scoreboard queue when offered and
// popped when the device model has sampled a full frame. Timing parameters
// are scaled down so the whole run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

   localparam int F   = 4;      // filter length
   localparam int INH = 200;    // inhibit cycles
   localparam int ST  = 3000;   // start timeout
   localparam int ET  = 1000;   // edge timeout
   localparam int H   = 20;     // device clock half period, in clk cycles

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       dev_clk  = 1'b1;   // device side of the lines, 1 = released
   logic       dev_data = 1'b1;
   logic       kclk_in;
   logic       kdata_in;
   logic       kclk_oe;
   logic       kdata_oe;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err;

   int n_tests     = 0;
   int n_fail      = 0;
   int done_pulses = 0;
   int err_pulses  = 0;
   int both_pulses = 0;

   logic [7:0]  exp_q[$];
   logic [10:0] smp;          // {stop, parity, data[7:0], start} as sampled

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device
   assign kclk_in  = dev_clk  & ~kclk_oe;
   assign kdata_in = dev_data & ~kdata_oe;

   ps2_host_tx #(
      .FILTER_CYC        (F),
      .INHIBIT_CYC       (INH),
      .START_TIMEOUT_CYC (ST),
      .EDGE_TIMEOUT_CYC  (ET)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .kclk_in  (kclk_in),
      .kdata_in (kdata_in),
      .kclk_oe  (kclk_oe),
      .kdata_oe (kdata_oe),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // Pulse counters (read pre-update values at the edge)
   always @(posedge clk) begin
      if (done) done_pulses++;
      if (err) err_pulses++;
      if (done && err) both_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offer one byte with a single-cycle tx_valid
   task automatic send(input logic [7:0] b);
      check("ready_before_send", {31'd0, tx_ready}, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0;
      check("busy_after_accept", {30'd0, tx_ready, busy}, 32'd1);
   endtask

   // Inhibit length and request-to-send ordering; returns on the first
   // cycle with the clock released.
   task automatic req_phase(input bit chk_inh);
      int cnt   = 0;
      int guard = 0;
      while (!kdata_oe && guard < INH + 50) begin
         if (kclk_oe) cnt++;
         guard++;
         @(negedge clk);
      end
      if (chk_inh) check("inhibit_len", cnt, INH);
      check("req_clk_held", {31'd0, kclk_oe}, 32'd1);
      @(negedge clk);
      check("req_clk_release", {30'd0, kclk_oe, kdata_oe}, 32'd1);
   endtask

   // Device generates npulses clocks; samples on each rising edge
   task automatic frame(input int npulses, input bit ack);
      smp = 11'h7FF;
      cyc(H);
      smp[0] = kdata_in;
      for (int k = 1; k <= npulses; k++) begin
         dev_clk = 1'b0;
         cyc(H);
         dev_clk = 1'b1;
         if (k == 11) dev_data = 1'b1;
         if (k <= 10) smp[k] = kdata_in;
         cyc(H / 2);
         if (k == 10 && ack) dev_data = 1'b0;
         cyc(H / 2);
      end
   endtask

   task automatic check_frame();
      logic [7:0] e;
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check("start_bit", {31'd0, smp[0]}, 32'd0);
      check("data_bits", {24'd0, smp[8:1]}, {24'd0, e});
      check("parity_bit", {31'd0, smp[9]}, {31'd0, ~^e});
      check("stop_bit", {31'd0, smp[10]}, 32'd1);
   endtask

   task automatic wait_outcome(input int d0, input int e0, input bit exp_done);
      int g = 0;
      while (done_pulses == d0 && err_pulses == e0 && g < ET) begin
         @(negedge clk);
         g++;
      end
      cyc(3);
      check("done_count", done_pulses - d0, {31'd0, exp_done});
      check("err_count", err_pulses - e0, {31'd0, !exp_done});
      check("post_idle", {28'd0, tx_ready, busy, kclk_oe, kdata_oe}, 32'd8);
   endtask

   // Hang guard
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      int e0;
      int cnt;

      // Reset values
      rst_n = 1'b0;
      cyc(3);
      check("reset_outs", {26'd0, kclk_oe, kdata_oe, tx_ready, busy, done, err}, 32'h08);
      rst_n = 1'b1;
      cyc(2 * F + 5);

      // 0xED with ACK
      d0 = done_pulses; e0 = err_pulses;
      send(8'hED);
      req_phase(1'b1);
      frame(11, 1'b1);
      check("parity_ED", {31'd0, smp[9]}, 32'd1);
      check_frame();
      wait_outcome(d0, e0, 1'b1);

      // 0x01 and 0x00: parity 0 and 1
      d0 = done_pulses; e0 = err_pulses;
      send(8'h01);
      req_phase(1'b1);
      frame(11, 1'b1);
      check("parity_01", {31'd0, smp[9]}, 32'd0);
      check_frame();
      wait_outcome(d0, e0, 1'b1);

      d0 = done_pulses; e0 = err_pulses;
      send(8'h00);
      req_phase(1'b1);
      frame(11, 1'b1);
      check("parity_00", {31'd0, smp[9]}, 32'd1);
      check_frame();
      wait_outcome(d0, e0, 1'b1);

      // Missing ACK
      d0 = done_pulses; e0 = err_pulses;
      send(8'hF0);
      req_phase(1'b1);
      frame(11, 1'b0);
      check_frame();
      wait_outcome(d0, e0, 1'b0);

      // Device never clocks: err exactly ST cycles after clock release
      d0 = done_pulses; e0 = err_pulses;
      send(8'hFF);
      req_phase(1'b1);
      cnt = 0;
      while (!err && cnt < ST + 50) begin
         @(negedge clk);
         cnt++;
      end
      check("start_timeout", cnt, ST);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      wait_outcome(d0, e0, 1'b0);

      // Device stalls after the 4th falling edge
      d0 = done_pulses; e0 = err_pulses;
      send(8'hA5);
      req_phase(1'b1);
      frame(3, 1'b0);
      dev_clk = 1'b0;
      cnt = 0;
      while (!err && cnt < ET + F + 50) begin
         @(negedge clk);
         cnt++;
         if (cnt == H) dev_clk = 1'b1;
      end
      check("edge_timeout", cnt, ET + F + 4);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      wait_outcome(d0, e0, 1'b0);

      // tx_valid held high: 0xFF then 0xED, toggles while busy ignored
      d0 = done_pulses; e0 = err_pulses;
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      exp_q.push_back(8'hFF);
      @(negedge clk);
      tx_data = 8'hED;
      exp_q.push_back(8'hED);
      check("stream_busy", {30'd0, tx_ready, busy}, 32'd1);
      req_phase(1'b1);
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1'b0;
         cyc(1);
         tx_valid = 1'b1;
         cyc(1);
      end
      frame(11, 1'b1);
      tx_valid = 1'b0;
      check_frame();
      check("stream_done1", done_pulses - d0, 32'd1);
      d0 = done_pulses;
      req_phase(1'b0);
      frame(11, 1'b1);
      check_frame();
      wait_outcome(d0, e0, 1'b1);
      check("stream_sb_drained", {31'd0, exp_q.size() == 0}, 32'd1);

      // Reset at the 5th falling edge of a 0x00 frame
      send(8'h00);
      req_phase(1'b1);
      frame(4, 1'b1);
      check("pre_rst_data_low", {31'd0, kdata_oe}, 32'd1);
      dev_clk = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      check("rst_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
      check("rst_status", {28'd0, tx_ready, busy, done, err}, 32'd8);
      rst_n   = 1'b1;
      dev_clk = 1'b1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      d0 = done_pulses; e0 = err_pulses;
      cyc(2 * ET);
      check("no_pulse_after_rst", (done_pulses - d0) + (err_pulses - e0), 32'd0);

      // Normal byte after reset
      d0 = done_pulses; e0 = err_pulses;
      send(8'hFF);
      req_phase(1'b1);
      frame(11, 1'b1);
      check_frame();
      wait_outcome(d0, e0, 1'b1);

      check("never_both", both_pulses, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
